// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud state encoding and sync-character constants.
package uart_pkg;

  localparam int unsigned DEF_CNT_W  = 24;
  localparam int unsigned SYNC_EDGES = 8;
  localparam int unsigned SYNC_SHIFT = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    MEASURE,
    STOP_CHK,
    LOCKED
  } autobaud_state_e;

endpackage

// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the autobaud detector and the UART bridge.
// baud_rate exists only when UART_AUTOBAUD_RATE_OUT_EN is defined.
interface uart_autobaud_if
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             enable;
  logic             arm;
  logic             rx;
  logic [CNT_W-1:0] bit_cycles;
  logic             locked;
  logic             busy;
  logic             error;
`ifdef UART_AUTOBAUD_RATE_OUT_EN
  logic [31:0]      baud_rate;

  modport master (output enable, arm, rx,
                  input  bit_cycles, locked, busy, error, baud_rate);
  modport slave  (input  enable, arm, rx,
                  output bit_cycles, locked, busy, error, baud_rate);
`else
  modport master (output enable, arm, rx,
                  input  bit_cycles, locked, busy, error);
  modport slave  (input  enable, arm, rx,
                  output bit_cycles, locked, busy, error);
`endif
endinterface

// File: rtl/rx_sync_edge.sv
// 2-FF synchronizer for an asynchronous serial line with registered rise/fall pulses.
// Pulses appear 3 cycles after the pin changes; level is aligned with the pulses.
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1;
  logic s2;

  // Reset to the idle-high line level so no edge is reported out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
      fall  <= ~s2 & level;
    end
  end
endmodule

// File: rtl/uart_autobaud.sv
// Measures clock cycles per bit from a 0x55 sync character on rx.
// Define UART_AUTOBAUD_RATE_OUT_EN to add the derived baud_rate output.
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned MIN_BIT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_autobaud_if.slave  io
);
  localparam int unsigned CW1    = CNT_W + 1;
  localparam int unsigned EDGE_W = $clog2(SYNC_EDGES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  autobaud_state_e   state;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  interval;
  logic [CNT_W-1:0]  ref_len;
  logic [EDGE_W-1:0] edge_cnt;
  logic [CNT_W-1:0]  stop_cnt;
  logic [CNT_W-1:0]  bc_next;
  logic              seen_high;
  logic              seen_rise;
  logic [CNT_W-1:0]  bit_cycles_q;
  logic              locked_q;
  logic              busy_q;
  logic              error_q;

  logic rx_level;
  logic rx_rise;
  logic rx_fall;

  rx_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io.rx),
    .level (rx_level),
    .rise  (rx_rise),
    .fall  (rx_fall)
  );

  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] total_now;
  logic [CW1-1:0]   win_lo;
  logic [CW1-1:0]   win_hi;
  logic [CW1-1:0]   bc_sum;
  logic [CNT_W-1:0] bc_calc;
  logic             edge_any;
  logic             too_short;
  logic             out_of_win;
  logic             saturated;
  logic             last_edge;
  logic             fail;

  // Interval checks; the window is widened by one bit so ref + ref/4 cannot wrap.
  always_comb begin
    cur_len    = interval + CNT_W'(1);
    total_now  = total + CNT_W'(1);
    win_lo     = CW1'(ref_len) - CW1'(ref_len >> 2);
    win_hi     = CW1'(ref_len) + CW1'(ref_len >> 2);
    bc_sum     = CW1'(total_now) + CW1'(1 << (SYNC_SHIFT - 1));
    bc_calc    = CNT_W'(bc_sum >> SYNC_SHIFT);
    edge_any   = rx_rise | rx_fall;
    too_short  = cur_len < CNT_W'(MIN_BIT_CYCLES);
    out_of_win = (edge_cnt != '0) &&
                 ((CW1'(cur_len) < win_lo) || (CW1'(cur_len) > win_hi));
    saturated  = (total_now == CNT_MAX);
    last_edge  = (edge_cnt == EDGE_W'(SYNC_EDGES - 1));
    fail       = ((state == MEASURE) && (saturated || (edge_any && (too_short || out_of_win)))) ||
                 ((state == STOP_CHK) && rx_fall);
  end

`ifdef UART_AUTOBAUD_RATE_OUT_EN
  logic [31:0] baud_q;
  logic [31:0] baud_calc;

  always_comb begin
    baud_calc = '0;
    if (bc_next != '0) baud_calc = 32'(64'(CLK_FREQ) / 64'(bc_next));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      baud_q <= '0;
    else if (io.enable && !io.arm && !fail && (state == STOP_CHK) && !rx_rise &&
             seen_rise && (stop_cnt + CNT_W'(1) == bc_next))
      baud_q <= baud_calc;
  end

  assign io.baud_rate = baud_q;
`endif

  // Control FSM; enable dominates, then error/arm restart, then normal progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      total        <= '0;
      interval     <= '0;
      ref_len      <= '0;
      edge_cnt     <= '0;
      stop_cnt     <= '0;
      bc_next      <= '0;
      seen_high    <= 1'b0;
      seen_rise    <= 1'b0;
      bit_cycles_q <= '0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (!io.enable) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else if (fail || io.arm) begin
        state     <= WAIT_START;
        busy_q    <= 1'b1;
        seen_high <= 1'b0;
        error_q   <= fail;
        if (io.arm) locked_q <= 1'b0;
      end else begin
        case (state)
          WAIT_START: begin
            if (rx_fall && seen_high) begin
              state    <= MEASURE;
              total    <= '0;
              interval <= '0;
              edge_cnt <= '0;
            end else if (rx_level) begin
              seen_high <= 1'b1;
            end
          end
          MEASURE: begin
            total <= total_now;
            if (edge_any) begin
              interval <= '0;
              edge_cnt <= edge_cnt + EDGE_W'(1);
              if (edge_cnt == '0) ref_len <= cur_len;
              if (last_edge) begin
                state     <= STOP_CHK;
                bc_next   <= bc_calc;
                seen_rise <= 1'b0;
                stop_cnt  <= '0;
              end
            end else begin
              interval <= cur_len;
            end
          end
          STOP_CHK: begin
            // The rise cycle counts as the first high cycle of the stop bit.
            if (rx_rise) begin
              seen_rise <= 1'b1;
              stop_cnt  <= CNT_W'(1);
            end else if (seen_rise) begin
              if (stop_cnt + CNT_W'(1) == bc_next) begin
                bit_cycles_q <= bc_next;
                locked_q     <= 1'b1;
                busy_q       <= 1'b0;
                state        <= LOCKED;
              end else begin
                stop_cnt <= stop_cnt + CNT_W'(1);
              end
            end
          end
          IDLE, LOCKED: ;
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io.bit_cycles = bit_cycles_q;
  assign io.locked     = locked_q;
  assign io.busy       = busy_q;
  assign io.error      = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Randomized and directed bench for uart_autobaud against an interval-list reference model.
module tb_uart_autobaud;
  import uart_pkg::*;

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned MIN_BC = 4;
  localparam int unsigned CLK_HZ = 50_000_000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_autobaud_if #(.CNT_W(CNT_W)) io();

  uart_autobaud #(
    .CLK_FREQ       (CLK_HZ),
    .CNT_W          (CNT_W),
    .MIN_BIT_CYCLES (MIN_BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int err_run = 0;
  int err_run_max = 0;
  int bc_prev = 0;
  int iv[8];

  // Count error pulses and the longest run of consecutive high cycles.
  always @(negedge clk) begin
    if (io.error === 1'b1) begin
      err_cnt++;
      err_run++;
      if (err_run > err_run_max) err_run_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    io.arm = 1'b1;
    step(1);
    io.arm = 1'b0;
  endtask

  // Reference: eight start-to-fifth-fall intervals must each be legal, the result
  // is their rounded mean, and the stop bit must stay high at least that long.
  function automatic int model_bc();
    int sum = 0;
    for (int i = 0; i < 8; i++) sum += iv[i];
    return (sum + 4) / 8;
  endfunction

  function automatic bit model_ok(input int stop_len);
    int lo = iv[0] - iv[0] / 4;
    int hi = iv[0] + iv[0] / 4;
    bit ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (iv[i] < int'(MIN_BC)) ok = 1'b0;
      if (i > 0 && (iv[i] < lo || iv[i] > hi)) ok = 1'b0;
    end
    if (stop_len < model_bc()) ok = 1'b0;
    return ok;
  endfunction

  // Drive one 0x55 frame from iv[]; stop_short > 0 drops the line that far into the stop bit.
  task automatic run_case(input string tag, input int d7_len, input int stop_short);
    int  bc = model_bc();
    bit  ok = model_ok(stop_short > 0 ? stop_short : 32'h3fff_ffff);
    int  e0;
    io.rx = 1'b1;
    pulse_arm();
    e0 = err_cnt;
    step(4);
    for (int i = 0; i < 8; i++) begin
      io.rx = (i % 2 == 1);
      step(iv[i]);
    end
    io.rx = 1'b0;
    step(d7_len);
    io.rx = 1'b1;
    if (stop_short > 0) begin
      step(stop_short);
      io.rx = 1'b0;
      step(20);
      io.rx = 1'b1;
    end
    step(bc + 40);
    if (ok) begin
      check_eq({tag, "_locked"}, 64'(io.locked), 64'(1));
      check_eq({tag, "_bit_cycles"}, 64'(io.bit_cycles), 64'(bc));
      check_eq({tag, "_no_error"}, 64'(err_cnt - e0), 64'(0));
      check_eq({tag, "_busy"}, 64'(io.busy), 64'(0));
`ifdef UART_AUTOBAUD_RATE_OUT_EN
      check_eq({tag, "_baud_rate"}, 64'(io.baud_rate), 64'(CLK_HZ / bc));
`endif
      bc_prev = bc;
    end else begin
      check_eq({tag, "_locked"}, 64'(io.locked), 64'(0));
      check_eq({tag, "_bit_cycles_kept"}, 64'(io.bit_cycles), 64'(bc_prev));
      check_eq({tag, "_error_seen"}, 64'((err_cnt - e0) > 0), 64'(1));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, j, kind, idx, bc, e0;
    io.enable = 1'b1;
    io.arm    = 1'b0;
    io.rx     = 1'b1;
    step(3);
    check_eq("rst_bit_cycles", 64'(io.bit_cycles), 64'(0));
    check_eq("rst_locked", 64'(io.locked), 64'(0));
    check_eq("rst_busy", 64'(io.busy), 64'(0));
    check_eq("rst_error", 64'(io.error), 64'(0));
`ifdef UART_AUTOBAUD_RATE_OUT_EN
    check_eq("rst_baud_rate", 64'(io.baud_rate), 64'(0));
`endif
    reset = 1'b0;
    step(3);

    for (int i = 0; i < 8; i++) iv[i] = 434;
    run_case("nom115200", 434, 0);
    check_eq("nom115200_const", 64'(io.bit_cycles), 64'(434));
`ifdef UART_AUTOBAUD_RATE_OUT_EN
    check_eq("nom115200_rate_const", 64'(io.baud_rate), 64'(115207));
`endif

    for (int i = 0; i < 8; i++) iv[i] = (i % 2 == 0) ? 400 : 468;
    run_case("jitter", 434, 0);

    for (int i = 0; i < 8; i++) iv[i] = 5208;
    run_case("nom9600", 5208, 0);
    check_eq("nom9600_const", 64'(io.bit_cycles), 64'(5208));
`ifdef UART_AUTOBAUD_RATE_OUT_EN
    check_eq("nom9600_rate_const", 64'(io.baud_rate), 64'(9600));
`endif

    for (int i = 0; i < 8; i++) iv[i] = 434;
    run_case("stop_viol", 434, 200);
    check_eq("stop_viol_keep_5208", 64'(io.bit_cycles), 64'(5208));

    // Glitch: two-cycle low pulse on an idle line after arming.
    io.rx = 1'b1;
    pulse_arm();
    e0 = err_cnt;
    step(4);
    io.rx = 1'b0;
    step(2);
    io.rx = 1'b1;
    step(12);
    check_eq("glitch_error_once", 64'(err_cnt - e0), 64'(1));
    check_eq("glitch_busy_wait_start", 64'(io.busy), 64'(1));
    check_eq("glitch_locked", 64'(io.locked), 64'(0));
    check_eq("glitch_bit_cycles_kept", 64'(io.bit_cycles), 64'(bc_prev));

    // Enable low forces IDLE and ignores arm.
    io.enable = 1'b0;
    step(2);
    check_eq("disable_busy", 64'(io.busy), 64'(0));
    pulse_arm();
    step(2);
    check_eq("disable_arm_ignored", 64'(io.busy), 64'(0));
    io.enable = 1'b1;
    step(2);

    for (int t = 0; t < 8; t++) begin
      p = int'($urandom_range(8, 100));
      j = p / 16;
      for (int i = 0; i < 8; i++) iv[i] = p - j + int'($urandom_range(0, 2 * j));
      kind = int'($urandom_range(0, 3));
      idx  = int'($urandom_range(0, 7));
      if (kind == 1) iv[idx] = iv[idx] * 3 / 2;
      if (kind == 2) iv[idx] = int'($urandom_range(1, 3));
      bc = model_bc();
      run_case($sformatf("rand%0d", t), p, (kind == 3) ? ((bc / 2 > 0) ? bc / 2 : 1) : 0);
    end

    // Reset in the middle of a measurement, then a clean lock.
    for (int i = 0; i < 8; i++) iv[i] = 100;
    io.rx = 1'b1;
    pulse_arm();
    step(4);
    for (int i = 0; i < 3; i++) begin
      io.rx = (i % 2 == 1);
      step(iv[i]);
    end
    io.rx = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("midrst_bit_cycles", 64'(io.bit_cycles), 64'(0));
    check_eq("midrst_locked", 64'(io.locked), 64'(0));
    check_eq("midrst_busy", 64'(io.busy), 64'(0));
    check_eq("midrst_error", 64'(io.error), 64'(0));
`ifdef UART_AUTOBAUD_RATE_OUT_EN
    check_eq("midrst_baud_rate", 64'(io.baud_rate), 64'(0));
`endif
    bc_prev = 0;
    step(2);
    reset = 1'b0;
    step(3);
    run_case("post_reset", 100, 0);

    check_eq("error_pulse_width", 64'(err_run_max), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
